// File: rtl/ring_pkg.sv
// Shared types, constants and helpers for the ring counter monitor.
package ring_pkg;

    typedef enum logic [1:0] {
        RING_ACQUIRE = 2'd0,
        RING_LOCKED  = 2'd1,
        RING_FAULT   = 2'd2
    } ring_mon_state_t;

    localparam int unsigned RING_ERR_W = 8;
    // Widest ring the helpers accept; callers zero-extend narrower vectors.
    localparam int unsigned RING_MAX_W = 64;

    // True when exactly one bit is set.
    function automatic logic ring_is_onehot(input logic [RING_MAX_W-1:0] v);
        return $onehot(v);
    endfunction

    // Rotate a w-bit vector right by one (bit 0 wraps to bit w-1).
    function automatic logic [RING_MAX_W-1:0] ring_rotr(input logic [RING_MAX_W-1:0] v,
                                                        input int unsigned           w);
        logic [RING_MAX_W-1:0] r;
        r        = v >> 1;
        r[w-1]   = v[0];
        return r;
    endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Monitor bus: sampled ring code plus clear in, decoded status out.
interface ring_monitor_if
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAP_W = 8
);
    localparam int unsigned PHASE_W = $clog2(WIDTH);

    logic [WIDTH-1:0]      q;
    logic                  clear;
    logic [PHASE_W-1:0]    phase;
    logic                  phase_valid;
    logic                  locked;
    logic                  fault;
    logic                  lap_pulse;
    logic [LAP_W-1:0]      lap_count;
    logic [RING_ERR_W-1:0] err_count;

    modport master (
        output q, clear,
        input  phase, phase_valid, locked, fault, lap_pulse, lap_count, err_count
    );

    modport slave (
        input  q, clear,
        output phase, phase_valid, locked, fault, lap_pulse, lap_count, err_count
    );
endinterface

// File: rtl/ring_monitor_phase_enc.sv
// Combinational one-hot to index encoder; index counted from the MSB.
module ring_phase_enc
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]         vec_i,
    output logic [$clog2(WIDTH)-1:0] idx_c_o,
    output logic                     valid_c_o
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    // Index of the set bit, forced to zero for any non-one-hot code.
    always_comb begin
        idx_c_o   = '0;
        valid_c_o = ring_is_onehot(RING_MAX_W'(vec_i));
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) idx_c_o = IDX_W'(WIDTH - 1 - i);
        end
        if (!valid_c_o) idx_c_o = '0;
    end
endmodule

// File: rtl/ring_monitor.sv
// Ring counter sequence checker: phase decode, lock tracking, lap and error counts.
// Optional: RING_MONITOR_ERRCNT_EN keeps the saturating err_count; otherwise it is tied to 0.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LAP_W    = 8,
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic           clk,
    input  logic           reset,
    ring_monitor_if.slave  bus
);
    localparam int unsigned PHASE_W = $clog2(WIDTH);
    localparam int unsigned STEP_W  = 4;
    localparam logic [1:0]  ST_ACQUIRE = 2'(RING_ACQUIRE);
    localparam logic [1:0]  ST_LOCKED  = 2'(RING_LOCKED);
    localparam logic [1:0]  ST_FAULT   = 2'(RING_FAULT);
    localparam logic [WIDTH-1:0] CODE_LAST  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CODE_FIRST = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [WIDTH-1:0]      prev_q;
    logic [PHASE_W-1:0]    phase_q;
    logic                  phase_valid_q;
    logic                  lap_pulse_q, lap_pulse_d;
    logic [LAP_W-1:0]      lap_count_q, lap_count_d;
    logic [RING_ERR_W-1:0] err_q;
`ifdef RING_MONITOR_ERRCNT_EN
    logic [RING_ERR_W-1:0] err_d;
`endif

    logic [PHASE_W-1:0]    enc_idx;
    logic                  onehot;
    logic [WIDTH-1:0]      exp_code;
    logic                  advance, illegal, lap;

    ring_phase_enc #(.WIDTH(WIDTH)) u_enc (
        .vec_i     (bus.q),
        .idx_c_o   (enc_idx),
        .valid_c_o (onehot)
    );

    // Classify the current sample against the previous one.
    always_comb begin
        exp_code = WIDTH'(ring_rotr(RING_MAX_W'(prev_q), WIDTH));
        advance  = onehot && (bus.q == exp_code) && ring_is_onehot(RING_MAX_W'(prev_q));
        illegal  = !onehot || !((bus.q == exp_code) || (bus.q == prev_q));
        lap      = (prev_q == CODE_LAST) && (bus.q == CODE_FIRST);
    end

    // Next state and counter updates; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        lap_count_d = lap_count_q;
        lap_pulse_d = 1'b0;
`ifdef RING_MONITOR_ERRCNT_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_ACQUIRE: begin
                if (illegal) begin
                    step_d = '0;
                end else if (advance) begin
                    if (STEP_W'(step_q + STEP_W'(1)) >= STEP_W'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                        step_d  = '0;
                    end else begin
                        step_d = STEP_W'(step_q + STEP_W'(1));
                    end
                end
            end
            ST_LOCKED: begin
                if (illegal) begin
                    state_d = ST_FAULT;
`ifdef RING_MONITOR_ERRCNT_EN
                    if (err_q != '1) err_d = RING_ERR_W'(err_q + RING_ERR_W'(1));
`endif
                end else if (lap) begin
                    lap_pulse_d = 1'b1;
                    lap_count_d = LAP_W'(lap_count_q + LAP_W'(1));
                end
            end
            ST_FAULT: begin
                if (onehot) begin
                    state_d = ST_ACQUIRE;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
                step_d  = '0;
            end
        endcase
        if (bus.clear) begin
            state_d     = ST_ACQUIRE;
            step_d      = '0;
            lap_count_d = '0;
            lap_pulse_d = 1'b0;
`ifdef RING_MONITOR_ERRCNT_EN
            err_d       = '0;
`endif
        end
    end

    // State, history and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ACQUIRE;
            step_q        <= '0;
            prev_q        <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            lap_pulse_q   <= 1'b0;
            lap_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            prev_q        <= bus.q;
            phase_q       <= enc_idx;
            phase_valid_q <= onehot;
            lap_pulse_q   <= lap_pulse_d;
            lap_count_q   <= lap_count_d;
        end
    end

`ifdef RING_MONITOR_ERRCNT_EN
    // Saturating count of illegal events seen while locked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= '0;
        else        err_q <= err_d;
    end
`else
    assign err_q = '0;
`endif

    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.lap_pulse   = lap_pulse_q;
    assign bus.lap_count   = lap_count_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_ring_monitor.sv
// Scoreboard bench for ring_monitor (WIDTH=4, LAP_W=8, LOCK_CNT=2).
module tb_ring_monitor;
    logic clk;
    logic reset;

    ring_monitor_if #(.WIDTH(4), .LAP_W(8)) bus ();

    ring_monitor #(.WIDTH(4), .LAP_W(8), .LOCK_CNT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] phase;
        logic       pv;
        logic       locked;
        logic       fault;
        logic       pulse;
        logic [7:0] laps;
        logic [7:0] errs;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Independent reference model state.
    logic [3:0] m_prev;
    int         m_state;
    int         m_step;
    logic [7:0] m_laps;
    logic [7:0] m_errs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = 4'b0000;
        m_state = 0;
        m_step  = 0;
        m_laps  = 8'd0;
        m_errs  = 8'd0;
    endtask

    // Drive one sample at the falling edge, predict, clock it, then compare.
    task automatic step(input logic [3:0] qv, input logic clr);
        exp_t       e;
        logic [3:0] rot;
        logic       oh, adv, ill, lapev;
        bus.q     = qv;
        bus.clear = clr;
        rot   = {m_prev[0], m_prev[3:1]};
        oh    = $onehot(qv);
        adv   = oh && (qv == rot) && $onehot(m_prev);
        ill   = !oh || !((qv == rot) || (qv == m_prev));
        lapev = (m_prev == 4'b0001) && (qv == 4'b1000);
        e.pulse = 1'b0;
        if (clr) begin
            m_state = 0; m_step = 0; m_laps = 8'd0; m_errs = 8'd0;
        end else begin
            case (m_state)
                0: if (ill) m_step = 0;
                   else if (adv) begin
                       m_step++;
                       if (m_step >= 2) begin m_state = 1; m_step = 0; end
                   end
                1: if (ill) begin
                       m_state = 2;
                       if (m_errs != 8'hFF) m_errs++;
                   end else if (lapev) begin
                       e.pulse = 1'b1;
                       m_laps++;
                   end
                default: if (oh) begin m_state = 0; m_step = 0; end
            endcase
        end
        m_prev = qv;
        e.pv = oh;
        case (qv)
            4'b1000: e.phase = 2'd0;
            4'b0100: e.phase = 2'd1;
            4'b0010: e.phase = 2'd2;
            4'b0001: e.phase = 2'd3;
            default: e.phase = 2'd0;
        endcase
        e.locked = (m_state == 1);
        e.fault  = (m_state == 2);
        e.laps   = m_laps;
`ifdef RING_MONITOR_ERRCNT_EN
        e.errs   = m_errs;
`else
        e.errs   = 8'd0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("phase",       32'(bus.phase),       32'(e.phase));
        check("phase_valid", 32'(bus.phase_valid), 32'(e.pv));
        check("locked",      32'(bus.locked),      32'(e.locked));
        check("fault",       32'(bus.fault),       32'(e.fault));
        check("lap_pulse",   32'(bus.lap_pulse),   32'(e.pulse));
        check("lap_count",   32'(bus.lap_count),   32'(e.laps));
        check("err_count",   32'(bus.err_count),   32'(e.errs));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},  32'(bus.phase),       32'd0);
        check({tag, "_pv"},     32'(bus.phase_valid), 32'd0);
        check({tag, "_locked"}, 32'(bus.locked),      32'd0);
        check({tag, "_fault"},  32'(bus.fault),       32'd0);
        check({tag, "_pulse"},  32'(bus.lap_pulse),   32'd0);
        check({tag, "_laps"},   32'(bus.lap_count),   32'd0);
        check({tag, "_errs"},   32'(bus.err_count),   32'd0);
    endtask

    initial begin
        logic [3:0] r;
        reset     = 1'b0;
        bus.q     = 4'b1000;
        bus.clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;

        // Startup and 300 laps from 1000; lock after the second advancing sample.
        r = 4'b1000;
        for (int i = 0; i < 1201; i++) begin
            step(r, 1'b0);
            if (i == 2) check("lock_at_0010", 32'(bus.locked), 32'd1);
            if (i == 1) check("unlocked_at_0100", 32'(bus.locked), 32'd0);
            r = {r[0], r[3:1]};
        end
        check("laps_300_wrap", 32'(bus.lap_count), 32'd44);
        check("no_fault_300", 32'(bus.fault), 32'd0);

        // Multi-hot glitch, then reacquire.
        step(4'b0100, 1'b0);
        step(4'b0110, 1'b0);
        check("glitch_fault", 32'(bus.fault), 32'd1);
`ifdef RING_MONITOR_ERRCNT_EN
        check("glitch_err1", 32'(bus.err_count), 32'd1);
`endif
        step(4'b0010, 1'b0);
        check("reacq_state", 32'(bus.fault | bus.locked), 32'd0);
        step(4'b0001, 1'b0);
        step(4'b1000, 1'b0);
        check("relock_1000", 32'(bus.locked), 32'd1);

        // All-zero for three cycles: one error only.
        step(4'b0100, 1'b0);
        step(4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0);
            check("zero_pv", 32'(bus.phase_valid), 32'd0);
        end
`ifdef RING_MONITOR_ERRCNT_EN
        check("zero_err2", 32'(bus.err_count), 32'd2);
`endif
        step(4'b0010, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0100, 1'b0);

        // Stall on 0100 while locked.
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 1'b0);
            check("hold_locked", 32'(bus.locked), 32'd1);
        end

        // Clear on a lap edge.
        step(4'b0010, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b1000, 1'b1);
        check("clear_laps", 32'(bus.lap_count), 32'd0);
        check("clear_acq", 32'(bus.locked), 32'd0);
        step(4'b0100, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0001, 1'b0);

        // Async reset mid-cycle.
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(4'b0010, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b1000, 1'b0);
        check("post_rst_lock", 32'(bus.locked), 32'd1);

        // Mixed random codes and correct rotations.
        r = 4'b1000;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            else if ($onehot(r))           r = {r[0], r[3:1]};
            else                           r = 4'b1000;
            step(r, ($urandom_range(0, 31) == 0));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ring_monitor.md
# ring_monitor

Downstream checker for the 4-bit right-shifting ring counter: samples its one-hot `q` every clock, decodes the active phase, and locks onto the rotation sequence 1000→0100→0010→0001→1000. It counts completed laps and flags any illegal code or out-of-order step. It feeds status LEDs and the self-check logic of the shift-register application benches, and can sit on any ring counter's output without modifying it.

## Interface
- `WIDTH`, 4: ring length; must be ≥ 2.
- `LAP_W`, 8: lap counter width.
- `LOCK_CNT`, 2: consecutive legal steps required to declare lock; range 1..15.
- `clk` input 1: single clock; everything samples on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `q` input WIDTH: ring counter output; bit WIDTH-1 is phase 0.
- `clear` input 1: synchronous; zeroes `lap_count` and `err_count` and forces state ACQUIRE.
- `phase` output $clog2(WIDTH): index of the set bit, counted from the MSB (1000→0, 0001→3).
- `phase_valid` output 1: the last sample was exactly one-hot.
- `locked` output 1: state is LOCKED.
- `fault` output 1: state is FAULT.
- `lap_pulse` output 1: one-cycle pulse on each completed lap.
- `lap_count` output LAP_W: completed laps; wraps modulo 2^LAP_W.
- `err_count` output 8: illegal events; saturates at 255.

## Operation
- Each edge: register `q` into `prev`, compute `exp = {prev[0], prev[WIDTH-1:1]}`.
- A sample is **legal** if it is one-hot and equals `exp`, or if it equals `prev` (hold/stall).
- A sample is **illegal** if it is not one-hot (all-zero or multi-hot), or if it is one-hot but neither `exp` nor `prev`.
- States: ACQUIRE (2'd0), LOCKED (2'd1), FAULT (2'd2).
- **ACQUIRE:** a step counter counts legal *advancing* samples, meaning samples equal to `exp` with `prev` one-hot. Holds neither count nor reset the counter. An illegal sample zeroes the counter. When the counter reaches LOCK_CNT, go to LOCKED. No errors are counted in ACQUIRE.
- **LOCKED:**
  - A legal sample keeps the state.
  - An illegal sample moves to FAULT and increments `err_count`.
  - A lap is the transition `prev`=0…01 → `q`=10…0. A lap pulses `lap_pulse` and increments `lap_count`.
- **FAULT:** the first one-hot sample moves to ACQUIRE with the step counter at 0. Non-one-hot samples keep FAULT and add no further errors.
- Outputs for non-one-hot samples: `phase` = 0 and `phase_valid` = 0.
- `clear` has priority over all state transitions. It overrides any lap or error increment in the same cycle.
- Reset values:
  - State ACQUIRE, `prev` = 0, step counter 0.
  - `phase` = 0, `phase_valid` = 0, `locked` = 0, `fault` = 0.
  - `lap_pulse` = 0, `lap_count` = 0, `err_count` = 0.

## Timing
- All outputs are registered. A `q` value sampled at edge k is reflected in the outputs after edge k, giving 1-cycle latency.
- `locked` rises after the edge that captures the LOCK_CNT-th advancing step. With the ring leaving reset at 1000, `locked` = 1 after the 2nd rotation edge (LOCK_CNT=2).
- `fault` rises on the edge that captures the illegal sample. `err_count` increments on that same edge.
- `lap_pulse` is high for exactly one cycle, concurrent with `lap_count` updating.
- Asserting `reset` mid-lap clears everything immediately. Reacquisition starts from the first post-reset sample.

## Configuration
- `RING_MONITOR_ERRCNT_EN` defined: the `err_count` register and its saturation logic are present as specified.
- Not defined: `err_count` is tied to 0 and has no flops. `fault` and the state machine are unchanged.

## Structure
- Package `ring_pkg`:
  - State enum `ring_mon_state_t`.
  - Constant `RING_ERR_W` = 8.
  - Function `ring_is_onehot`.
  - Function `ring_rotr` (right rotate by one).
- Sub-module `ring_phase_enc`: combinational one-hot → index encoder with a valid flag, parameterised by WIDTH.

## Test plan
- Reset released, ring counter running from 1000 → `locked` = 1 after the second advancing edge; `phase` sequence 0,1,2,3,0…; `lap_pulse` on every 0001→1000.
- Run 300 laps with LAP_W=8 → `lap_count` wraps to 44 with no `fault`.
- While locked, force `q` = 0110 for one cycle → `fault` = 1 and `err_count` = 1. Then restore `q` = 0010, 0001, 1000 → ACQUIRE, then `locked` = 1 again at 1000.
- Force 0000 for 3 cycles while locked → `err_count` increments once; `phase_valid` = 0 for 3 cycles.
- Hold `q` = 0100 for 5 cycles while locked → no fault and no lap; `locked` stays 1.
- Raise `clear` on the same edge as a lap → `lap_count` = 0 and state ACQUIRE. Then assert `reset` mid-lap → all outputs 0 asynchronously.
